// File: rtl/laplace_pkg.sv
// Shared definitions for the Laplace sum sequencer.
// Provides the sequencer state encoding and the datapath width constants
// used by the interface, the top-level sequencer and the finish stage.
package laplace_pkg;

    localparam int PIX_W    = 8;
    localparam int LAP_W    = 11;
    localparam int PIX_MAX  = 255;
    localparam int ACC_HI_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD1 = 3'd1,
        ADD2 = 3'd2,
        ADD3 = 3'd3,
        FIN  = 3'd4,
        OUT  = 3'd5
    } state_t;

endpackage

// File: rtl/laplace_sum_sequencer_if.sv
// Stream interface of the Laplace sum sequencer.
// Input side : in_valid/in_ready handshake with the five neighbourhood pixels.
// Output side: out_valid/out_ready handshake with the signed Laplacian and
//              the display pixel.
// slave  modport: the sequencer's view.
// master modport: the producer/consumer view (neighbourhood source and
//                 result sink).
interface laplace_sum_sequencer_if;
    import laplace_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [PIX_W-1:0]        pix_n;
    logic [PIX_W-1:0]        pix_s;
    logic [PIX_W-1:0]        pix_e;
    logic [PIX_W-1:0]        pix_w;
    logic [PIX_W-1:0]        pix_c;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [LAP_W-1:0] lap_out;
    logic [PIX_W-1:0]        pix_out;

    modport slave (
        input  in_valid, pix_n, pix_s, pix_e, pix_w, pix_c, out_ready,
        output in_ready, out_valid, lap_out, pix_out
    );

    modport master (
        output in_valid, pix_n, pix_s, pix_e, pix_w, pix_c, out_ready,
        input  in_ready, out_valid, lap_out, pix_out
    );

endinterface

// File: rtl/laplace_finish.sv
// Combinational finish stage: lap = 4*C - sum10 at full 11-bit precision,
// then the display pixel (saturated magnitude or raw low byte).
// Ports:
//   c      in  8   centre pixel
//   acc_hi in  2   upper bits of the neighbour sum
//   acc_lo in  8   lower bits of the neighbour sum
//   lap    out 11  signed Laplacian, range -1020..+1020
//   pix    out 8   min(|lap|,255) when SAT_EN, else lap[7:0]
module laplace_finish
    import laplace_pkg::*;
#(
    parameter bit SAT_EN = 1'b1
) (
    input  logic [PIX_W-1:0]        c,
    input  logic [ACC_HI_W-1:0]     acc_hi,
    input  logic [PIX_W-1:0]        acc_lo,
    output logic signed [LAP_W-1:0] lap,
    output logic [PIX_W-1:0]        pix
);

    logic [LAP_W-1:0] c4_s;
    logic [LAP_W-1:0] sum_s;
    logic [LAP_W-1:0] diff_s;
    logic [LAP_W-1:0] mag_s;

    // Exact difference, magnitude and output pixel selection.
    always_comb begin
        c4_s   = {1'b0, c, 2'b00};
        sum_s  = {1'b0, acc_hi, acc_lo};
        diff_s = c4_s - sum_s;
        // |lap| <= 1020 so the negation never overflows 11 bits
        if (diff_s[LAP_W-1]) begin
            mag_s = ~diff_s + 11'd1;
        end else begin
            mag_s = diff_s;
        end
        lap = diff_s;
        if (SAT_EN) begin
            if (mag_s > LAP_W'(PIX_MAX)) begin
                pix = PIX_W'(PIX_MAX);
            end else begin
                pix = mag_s[PIX_W-1:0];
            end
        end else begin
            pix = diff_s[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/laplace_sum_sequencer.sv
// Multi-cycle 4-neighbour Laplacian, 4*C - (N+S+E+W).
// The three neighbour additions are time-multiplexed through an external
// 8-bit adder (exact or approximate); its sum/carry are used unmodified.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus (slave)         neighbourhood input and result output handshakes
//   add_a, add_b  out 8 operands to the external adder (0 outside ADDx)
//   add_cin       out 1 constant 0
//   add_s         in  8 adder sum, combinational in the same cycle
//   add_cout      in  1 adder carry-out
module laplace_sum_sequencer
    import laplace_pkg::*;
#(
    parameter bit SAT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    laplace_sum_sequencer_if.slave  bus,
    output logic [PIX_W-1:0]        add_a,
    output logic [PIX_W-1:0]        add_b,
    output logic                    add_cin,
    input  logic [PIX_W-1:0]        add_s,
    input  logic                    add_cout
);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [PIX_W-1:0]        pix_n_r, pix_s_r, pix_e_r, pix_w_r, pix_c_r;
    logic [PIX_W-1:0]        acc_lo_r;
    logic [ACC_HI_W-1:0]     acc_hi_r;
    logic signed [LAP_W-1:0] lap_r;
    logic [PIX_W-1:0]        pix_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [PIX_W-1:0]        add_a_s, add_b_s;
    logic signed [LAP_W-1:0] fin_lap_s;
    logic [PIX_W-1:0]        fin_pix_s;

    laplace_finish #(.SAT_EN(SAT_EN)) u_finish (
        .c      (pix_c_r),
        .acc_hi (acc_hi_r),
        .acc_lo (acc_lo_r),
        .lap    (fin_lap_s),
        .pix    (fin_pix_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and adder operand steering.
    always_comb begin
        state_next_s = state_r;
        add_a_s      = 8'd0;
        add_b_s      = 8'd0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next_s = ADD1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ADD1: begin
                add_a_s      = pix_n_r;
                add_b_s      = pix_s_r;
                state_next_s = ADD2;
            end
            ADD2: begin
                add_a_s      = acc_lo_r;
                add_b_s      = pix_e_r;
                state_next_s = ADD3;
            end
            ADD3: begin
                add_a_s      = acc_lo_r;
                add_b_s      = pix_w_r;
                state_next_s = FIN;
            end
            FIN: begin
                state_next_s = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pixel capture, carry accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_n_r  <= 8'd0;
            pix_s_r  <= 8'd0;
            pix_e_r  <= 8'd0;
            pix_w_r  <= 8'd0;
            pix_c_r  <= 8'd0;
            acc_lo_r <= 8'd0;
            acc_hi_r <= 2'd0;
            lap_r    <= 11'sd0;
            pix_r    <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        pix_n_r  <= bus.pix_n;
                        pix_s_r  <= bus.pix_s;
                        pix_e_r  <= bus.pix_e;
                        pix_w_r  <= bus.pix_w;
                        pix_c_r  <= bus.pix_c;
                        acc_lo_r <= 8'd0;
                        acc_hi_r <= 2'd0;
                    end
                end
                ADD1: begin
                    acc_lo_r <= add_s;
                    acc_hi_r <= {1'b0, add_cout};
                end
                ADD2, ADD3: begin
                    // at most three carries, so two bits never wrap
                    acc_lo_r <= add_s;
                    acc_hi_r <= acc_hi_r + {1'b0, add_cout};
                end
                FIN: begin
                    lap_r <= fin_lap_s;
                    pix_r <= fin_pix_s;
                end
                default: begin
                    lap_r <= lap_r;
                end
            endcase
        end
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == OUT);
        end
    end

    assign add_a         = add_a_s;
    assign add_b         = add_b_s;
    assign add_cin       = 1'b0;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.lap_out   = lap_r;
    assign bus.pix_out   = pix_r;

endmodule

// File: tb/tb_laplace_sum_sequencer.sv
// Bench for laplace_sum_sequencer: two instances (saturating and raw pixel
// output) run in lockstep against a selectable exact ripple / approximate
// adder model. Expected results are queued on accept and popped on output.
module tb_laplace_sum_sequencer;
    import laplace_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic approx_sel;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    laplace_sum_sequencer_if if_sat ();
    laplace_sum_sequencer_if if_raw ();

    logic [7:0] a_sat, b_sat, s_sat, a_raw, b_raw, s_raw;
    logic       cin_sat, cout_sat, cin_raw, cout_raw;

    typedef struct {
        int         lap;
        logic [7:0] pix_sat;
        logic [7:0] pix_raw;
    } exp_t;
    exp_t sb[$];

    logic [7:0] rn, rs, re, rw, rc;

    // Exact bit-serial ripple adder, or the approximate variant: upper nibble
    // is a plain OR, lower nibble added with its carry dropped, no carry-out.
    function automatic logic [8:0] adder(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic approx);
        logic [7:0] s;
        logic       c;
        logic [3:0] lo;
        if (approx) begin
            lo = a[3:0] + b[3:0];
            return {1'b0, a[7:4] | b[7:4], lo};
        end
        c = cin;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return {c, s};
    endfunction

    assign {cout_sat, s_sat} = adder(a_sat, b_sat, cin_sat, approx_sel);
    assign {cout_raw, s_raw} = adder(a_raw, b_raw, cin_raw, approx_sel);

    laplace_sum_sequencer #(.SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .bus(if_sat),
        .add_a(a_sat), .add_b(b_sat), .add_cin(cin_sat),
        .add_s(s_sat), .add_cout(cout_sat)
    );

    laplace_sum_sequencer #(.SAT_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .bus(if_raw),
        .add_a(a_raw), .add_b(b_raw), .add_cin(cin_raw),
        .add_s(s_raw), .add_cout(cout_raw)
    );

    function automatic logic [7:0] sat_of(input int lap);
        int mag;
        mag = (lap < 0) ? -lap : lap;
        return (mag > 255) ? 8'd255 : 8'(mag);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_px(input logic [7:0] n, s, e, w, c);
        if_sat.pix_n = n; if_sat.pix_s = s; if_sat.pix_e = e;
        if_sat.pix_w = w; if_sat.pix_c = c;
        if_raw.pix_n = n; if_raw.pix_s = s; if_raw.pix_e = e;
        if_raw.pix_w = w; if_raw.pix_c = c;
    endtask

    task automatic set_valid(input logic v);
        if_sat.in_valid = v;
        if_raw.in_valid = v;
    endtask

    task automatic set_oready(input logic v);
        if_sat.out_ready = v;
        if_raw.out_ready = v;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if_sat.in_ready) break;
        end
        chk("wait_in_ready", 32'(if_sat.in_ready), 32'sd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready_sat"},  32'(if_sat.in_ready), 32'sd1);
        chk({tag, "_in_ready_raw"},  32'(if_raw.in_ready), 32'sd1);
        chk({tag, "_out_valid_sat"}, 32'(if_sat.out_valid), 32'sd0);
        chk({tag, "_out_valid_raw"}, 32'(if_raw.out_valid), 32'sd0);
    endtask

    // Accept one neighbourhood on the next rising edge and queue its result.
    task automatic accept(input logic [7:0] n, s, e, w, c, input int exp_lap);
        exp_t x;
        set_px(n, s, e, w, c);
        set_valid(1'b1);
        @(posedge clk);
        x.lap     = exp_lap;
        x.pix_sat = sat_of(exp_lap);
        x.pix_raw = exp_lap[7:0];
        sb.push_back(x);
        #1;
        set_valid(1'b0);
        set_px(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic compare_pop();
        exp_t x;
        chk("out_valid_sat", 32'(if_sat.out_valid), 32'sd1);
        chk("out_valid_raw", 32'(if_raw.out_valid), 32'sd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'sd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("lap_out_sat", 32'(if_sat.lap_out), 32'(x.lap));
            chk("lap_out_raw", 32'(if_raw.lap_out), 32'(x.lap));
            chk("pix_out_sat", 32'(if_sat.pix_out), 32'(x.pix_sat));
            chk("pix_out_raw", 32'(if_raw.pix_out), 32'(x.pix_raw));
        end
    endtask

    // Full transaction with out_ready high; latency counts the accept edge.
    task automatic run(input logic [7:0] n, s, e, w, c, input int exp_lap,
                       input bit chk_lat);
        int lat;
        wait_ready();
        accept(n, s, e, w, c, exp_lap);
        lat = 1;
        while (!if_sat.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_lat) chk("latency", 32'(lat), 32'sd5);
        @(negedge clk);
        compare_pop();
        @(posedge clk);
        #1;
        check_idle("after_out");
    endtask

    initial begin
        rst = 1'b1;
        approx_sel = 1'b0;
        set_valid(1'b0);
        set_oready(1'b1);
        set_px(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_lap", 32'(if_sat.lap_out), 32'sd0);
        chk("reset_pix", 32'(if_sat.pix_out), 32'sd0);
        rst = 1'b0;

        // Uniform neighbourhood -> zero
        run(8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 0, 1'b1);
        // Bright centre: +800, saturates to 255 / raw 0x20
        run(8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 800, 1'b1);
        // All carries: sum 1020, lap -1020
        run(8'd255, 8'd255, 8'd255, 8'd255, 8'd0, -1020, 1'b0);

        // Back-pressure stall with an ignored second neighbourhood
        set_oready(1'b0);
        wait_ready();
        accept(8'd0, 8'd0, 8'd0, 8'd0, 8'd13, 52);
        for (int i = 0; i < 20; i++) begin
            if (if_sat.out_valid) break;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(if_sat.out_valid), 32'sd1);
            chk("stall_lap", 32'(if_sat.lap_out), 32'sd52);
            chk("stall_in_ready", 32'(if_sat.in_ready), 32'sd0);
            if (i == 2) begin
                set_px(8'd1, 8'd2, 8'd3, 8'd4, 8'd99);
                set_valid(1'b1);
            end
            if (i == 5) set_valid(1'b0);
        end
        @(negedge clk);
        set_oready(1'b1);
        compare_pop();
        @(posedge clk);
        #1;
        check_idle("stall_release");
        repeat (8) @(negedge clk);
        chk("ignored_no_output", 32'(if_sat.out_valid), 32'sd0);

        // Asynchronous reset during ADD2 drops the neighbourhood
        wait_ready();
        set_px(8'd9, 8'd9, 8'd9, 8'd9, 8'd200);
        set_valid(1'b1);
        @(posedge clk);
        #1;
        set_valid(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle("midreset");
        chk("midreset_lap", 32'(if_sat.lap_out), 32'sd0);
        chk("midreset_pix", 32'(if_sat.pix_out), 32'sd0);
        @(negedge clk);
        rst = 1'b0;
        run(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 10, 1'b1);

        // Random exact cases
        for (int i = 0; i < 4; i++) begin
            rn = 8'($urandom); rs = 8'($urandom); re = 8'($urandom);
            rw = 8'($urandom); rc = 8'($urandom);
            run(rn, rs, re, rw, rc,
                4 * int'(rc) - (int'(rn) + int'(rs) + int'(re) + int'(rw)), 1'b0);
        end

        // Approximate adder: 0x20 + 0x20 -> 0x20, consumed as-is
        approx_sel = 1'b1;
        run(8'h20, 8'h20, 8'h00, 8'h00, 8'h00, -32, 1'b0);
        approx_sel = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'sd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
